vx_interrupt_controller: RTL and testbench
==========================================

Name: vx_interrupt_controller

Overview:
- Interrupt controller (IRQC) inside the SIMT core scheduler. It accepts thread-transfer requests (wid, tid) from the scalar core (SC).
- It sequences the transfer FSM that the thread transfer unit (TTU) acts on, and snapshots the victim warp's PC, thread mask and active-warp mask.
- It steers the warp to the ISR, restores the warp when the ISR jumps back, and returns an ack or nack to the SC.
- It is the direct upstream/master of the TTU on the IRQC↔TTU interface.

Parameters:
- THREAD_CNT, `NUM_THREADS, threads per warp
- WARP_CNT, `NUM_WARPS, warps per core
- WARP_CNT_WIDTH, `LOG2UP(WARP_CNT), warp-id width
- THREAD_CNT_WIDTH, `LOG2UP(THREAD_CNT), thread-id width
- ISR_PC, 32'h8000_0000, ISR entry address loaded into the victim warp
- WAIT_TIMEOUT, 1024, max cycles in WAIT before nack
- XFER_CNT_W, 16, width of the transfer counter

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- irq_valid  in  1  SC transfer request
- irq_ready  out  1  request accepted (high only in IDLE)
- irq_wid  in  WARP_CNT_WIDTH  requested warp
- irq_tid  in  THREAD_CNT_WIDTH  requested thread
- resp_valid  out  1  one-cycle completion pulse to SC
- resp_ok  out  1  1 = thread transferred, 0 = nack
- ttu_state  out  irqc_state_t  FSM state driven to TTU
- ttu_wid  out  WARP_CNT_WIDTH  latched wid
- ttu_tid  out  THREAD_CNT_WIDTH  latched tid
- ttu_load_PC  out  `XLEN  ISR_PC in PC_SWAP; saved PC in REVERT_WARP
- ttu_load_tmask  out  THREAD_CNT  saved thread mask (REVERT_WARP)
- ttu_load_wmask  out  WARP_CNT  saved active-warp mask (REVERT_WARP)
- ttu_pipeline_drained  in  1  from TTU
- ttu_thread_found  in  1  from TTU
- ttu_current_thread_mask  in  THREAD_CNT  from TTU, valid in WAIT
- ttu_current_PC  in  `XLEN  from TTU, valid in WAIT
- ttu_current_active_warps  in  WARP_CNT  from TTU, valid in WAIT
- ttu_ISR_done  in  1  from TTU
- xfer_count  out  XFER_CNT_W  successful transfers, saturating

Behaviour:
- Reset (synchronous): state=IDLE; wid/tid/saved registers=0; timeout counter=0; xfer_count=0; resp_valid=0; resp_ok=0. irq_ready=1 the cycle after reset. Reset mid-transfer abandons the transfer and sends no response.
- IDLE: irq_ready=1.
  - irq_valid & ready: latch wid/tid.
  - If irq_wid>=WARP_CNT: stay IDLE, pulse resp_valid with resp_ok=0 next cycle.
  - Otherwise go to WAIT and clear the timeout counter.
- WAIT: timeout counter increments each cycle.
  - pipeline_drained & thread_found: capture current_PC, current_thread_mask and current_active_warps into saved registers; go to PC_SWAP.
  - pipeline_drained & !thread_found: go to IDLE, resp_valid=1, resp_ok=0.
  - Counter reaches WAIT_TIMEOUT-1 without drain: go to IDLE with nack.
  - Drain takes priority over timeout when both occur in the same cycle.
- PC_SWAP: exactly 1 cycle; ttu_load_PC=ISR_PC; go to WAIT_ISR.
- WAIT_ISR: hold until ttu_ISR_done=1, then go to REVERT_WARP. No timeout here, because the ISR is software-bounded.
- REVERT_WARP: exactly 1 cycle. ttu_load_PC=saved PC, ttu_load_tmask=saved tmask, ttu_load_wmask=saved wmask (the TTU clears tid/wid bits). Go to IDLE; resp_valid=1, resp_ok=1; xfer_count++ (saturates at all-ones).
- Responses: resp_valid and resp_ok are registered and appear one cycle after the transition out. There is no backpressure; the SC must sample on the pulse.
- ttu_load_* outside PC_SWAP/REVERT_WARP: drive 0.
- ttu_wid/ttu_tid hold their values from acceptance until the next acceptance.
- Minimum successful transfer: accept→WAIT(≥1)→PC_SWAP(1)→WAIT_ISR(≥1)→REVERT(1), response at REVERT+1.
- A new request can be accepted the cycle after returning to IDLE.

Decomposition:
- VX_gpu_pkg holds:
  - irqc_state_t enum, 3-bit: IRQC_IDLE=0, IRQC_WAIT=1, IRQC_PC_SWAP=2, IRQC_WAIT_ISR=3, IRQC_REVERT_WARP=4.
  - IRQC_ISR_PC_DEFAULT constant.
- The IRQC↔TTU port group maps 1:1 onto VX_interrupt_ctl_ttu_if (master modport).
- No sub-module; the saturating counter is inline.

Test Plan:
- Nominal transfer:
  - Stimulus: request wid=1, tid=2; drained+found after 3 cycles with PC=0x100, tmask=0xF, wmask=0x3; ISR_done 10 cycles later.
  - Required: PC_SWAP shows load_PC=0x8000_0000; REVERT shows PC=0x100, tmask=0xF, wmask=0x3; resp_ok=1; xfer_count=1.
- Thread absent: drained=1, found=0 in WAIT → return to IDLE, resp_valid=1, resp_ok=0, xfer_count unchanged.
- Timeout: WAIT_TIMEOUT=8, drained never asserts → nack 8 cycles after WAIT entry. Variant with drained and timeout in the same cycle → PC_SWAP is taken.
- Busy request: irq_valid held during WAIT_ISR → irq_ready=0 until IDLE, then accepted with the new wid/tid latched.
- Bad wid: WARP_CNT=3, irq_wid=3 → immediate nack; state never leaves IDLE.
- Reset mid-operation: reset asserted in WAIT_ISR → state=IDLE, no resp_valid, xfer_count=0, irq_ready=1 next cycle.

Source files
------------

// File: rtl/VX_gpu_pkg.sv
// rtl/VX_gpu_pkg.sv - shared types and constants for the SIMT core scheduler
package VX_gpu_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] IRQC_ISR_PC_DEFAULT = 32'h8000_0000;

    typedef enum logic [2:0] {
        IRQC_IDLE        = 3'd0,
        IRQC_WAIT        = 3'd1,
        IRQC_PC_SWAP     = 3'd2,
        IRQC_WAIT_ISR    = 3'd3,
        IRQC_REVERT_WARP = 3'd4
    } irqc_state_t;

endpackage

// File: rtl/vx_interrupt_controller.sv
// rtl/vx_interrupt_controller.sv - thread-transfer sequencer between the scalar core and the TTU
module vx_interrupt_controller
    import VX_gpu_pkg::*;
#(
    parameter int THREAD_CNT       = 4,
    parameter int WARP_CNT         = 4,
    parameter int WARP_CNT_WIDTH   = (WARP_CNT > 1) ? $clog2(WARP_CNT) : 1,
    parameter int THREAD_CNT_WIDTH = (THREAD_CNT > 1) ? $clog2(THREAD_CNT) : 1,
    parameter logic [XLEN-1:0] ISR_PC = IRQC_ISR_PC_DEFAULT,
    parameter int WAIT_TIMEOUT     = 1024,
    parameter int XFER_CNT_W       = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        irq_valid,
    output logic                        irq_ready,
    input  logic [WARP_CNT_WIDTH-1:0]   irq_wid,
    input  logic [THREAD_CNT_WIDTH-1:0] irq_tid,
    output logic                        resp_valid,
    output logic                        resp_ok,
    output irqc_state_t                 ttu_state,
    output logic [WARP_CNT_WIDTH-1:0]   ttu_wid,
    output logic [THREAD_CNT_WIDTH-1:0] ttu_tid,
    output logic [XLEN-1:0]             ttu_load_PC,
    output logic [THREAD_CNT-1:0]       ttu_load_tmask,
    output logic [WARP_CNT-1:0]         ttu_load_wmask,
    input  logic                        ttu_pipeline_drained,
    input  logic                        ttu_thread_found,
    input  logic [THREAD_CNT-1:0]       ttu_current_thread_mask,
    input  logic [XLEN-1:0]             ttu_current_PC,
    input  logic [WARP_CNT-1:0]         ttu_current_active_warps,
    input  logic                        ttu_ISR_done,
    output logic [XFER_CNT_W-1:0]       xfer_count
);

    localparam int TO_W = (WAIT_TIMEOUT > 2) ? $clog2(WAIT_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(WAIT_TIMEOUT - 1);

    irqc_state_t           state;
    logic [TO_W-1:0]       to_cnt;
    logic [XLEN-1:0]       saved_pc;
    logic [THREAD_CNT-1:0] saved_tmask;
    logic [WARP_CNT-1:0]   saved_wmask;

    assign irq_ready = (state == IRQC_IDLE);
    assign ttu_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IRQC_IDLE;
            to_cnt      <= '0;
            ttu_wid     <= '0;
            ttu_tid     <= '0;
            saved_pc    <= '0;
            saved_tmask <= '0;
            saved_wmask <= '0;
            xfer_count  <= '0;
            resp_valid  <= 1'b0;
            resp_ok     <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            resp_ok    <= 1'b0;
            case (state)
                IRQC_IDLE: begin
                    if (irq_valid) begin
                        ttu_wid <= irq_wid;
                        ttu_tid <= irq_tid;
                        // Out-of-range warp ids are refused without involving the TTU
                        if (32'(irq_wid) >= WARP_CNT) begin
                            resp_valid <= 1'b1;
                        end else begin
                            state  <= IRQC_WAIT;
                            to_cnt <= '0;
                        end
                    end
                end
                IRQC_WAIT: begin
                    if (ttu_pipeline_drained) begin
                        if (ttu_thread_found) begin
                            saved_pc    <= ttu_current_PC;
                            saved_tmask <= ttu_current_thread_mask;
                            saved_wmask <= ttu_current_active_warps;
                            state       <= IRQC_PC_SWAP;
                        end else begin
                            state      <= IRQC_IDLE;
                            resp_valid <= 1'b1;
                        end
                    end else if (to_cnt == TO_LAST) begin
                        state      <= IRQC_IDLE;
                        resp_valid <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                IRQC_PC_SWAP: state <= IRQC_WAIT_ISR;
                IRQC_WAIT_ISR: begin
                    if (ttu_ISR_done) begin
                        state <= IRQC_REVERT_WARP;
                    end
                end
                IRQC_REVERT_WARP: begin
                    state      <= IRQC_IDLE;
                    resp_valid <= 1'b1;
                    resp_ok    <= 1'b1;
                    if (xfer_count != {XFER_CNT_W{1'b1}}) begin
                        xfer_count <= xfer_count + 1'b1;
                    end
                end
                default: state <= IRQC_IDLE;
            endcase
        end
    end

    always_comb begin
        ttu_load_PC    = '0;
        ttu_load_tmask = '0;
        ttu_load_wmask = '0;
        case (state)
            IRQC_PC_SWAP: ttu_load_PC = ISR_PC;
            IRQC_REVERT_WARP: begin
                ttu_load_PC    = saved_pc;
                ttu_load_tmask = saved_tmask;
                ttu_load_wmask = saved_wmask;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_vx_interrupt_controller.sv
// tb/tb_vx_interrupt_controller.sv - scoreboard bench for the interrupt controller
module tb_vx_interrupt_controller;
    import VX_gpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        irq_valid = 1'b0;
    logic        irq_ready;
    logic [1:0]  irq_wid = '0;
    logic [1:0]  irq_tid = '0;
    logic        resp_valid, resp_ok;
    irqc_state_t ttu_state;
    logic [1:0]  ttu_wid, ttu_tid;
    logic [31:0] ttu_load_PC;
    logic [3:0]  ttu_load_tmask;
    logic [2:0]  ttu_load_wmask;
    logic        drained = 1'b0, found = 1'b0, isr_done = 1'b0;
    logic [3:0]  cur_tmask = '0;
    logic [31:0] cur_pc = '0;
    logic [2:0]  cur_wmask = '0;
    logic [15:0] xfer_count;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    typedef struct { logic ok; logic [15:0] cnt; int at; } resp_t;
    typedef struct { logic [31:0] pc; logic [1:0] wid; logic [1:0] tid; } swap_t;
    typedef struct { logic [31:0] pc; logic [3:0] tmask; logic [2:0] wmask; } rev_t;
    resp_t resp_q[$];
    swap_t swap_q[$];
    rev_t  rev_q[$];

    vx_interrupt_controller #(
        .THREAD_CNT(4), .WARP_CNT(3), .WAIT_TIMEOUT(8), .XFER_CNT_W(16)
    ) dut (
        .clk(clk), .reset(reset),
        .irq_valid(irq_valid), .irq_ready(irq_ready), .irq_wid(irq_wid), .irq_tid(irq_tid),
        .resp_valid(resp_valid), .resp_ok(resp_ok),
        .ttu_state(ttu_state), .ttu_wid(ttu_wid), .ttu_tid(ttu_tid),
        .ttu_load_PC(ttu_load_PC), .ttu_load_tmask(ttu_load_tmask), .ttu_load_wmask(ttu_load_wmask),
        .ttu_pipeline_drained(drained), .ttu_thread_found(found),
        .ttu_current_thread_mask(cur_tmask), .ttu_current_PC(cur_pc),
        .ttu_current_active_warps(cur_wmask), .ttu_ISR_done(isr_done),
        .xfer_count(xfer_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic request(input logic [1:0] w, input logic [1:0] t);
        int k = 0;
        logic rdy;
        irq_valid = 1'b1;
        irq_wid   = w;
        irq_tid   = t;
        do begin
            rdy = irq_ready;
            tick(1);
            k++;
        end while (!rdy && k < 20);
        irq_valid = 1'b0;
        chk("accept", {63'd0, rdy}, 64'd1);
    endtask

    task automatic wait_state(input irqc_state_t s, input int budget);
        int k = 0;
        while (ttu_state != s && k < budget) begin
            tick(1);
            k++;
        end
        chk("wait_state", {61'd0, ttu_state}, {61'd0, s});
    endtask

    // Monitor: every DUT-presented event is matched against the head of its queue
    always @(negedge clk) begin
        if (!reset) begin
            if (resp_valid) begin
                if (resp_q.size() == 0) begin
                    chk("unexpected_resp", 64'd1, 64'd0);
                end else begin
                    resp_t r;
                    r = resp_q.pop_front();
                    chk("resp_ok", {63'd0, resp_ok}, {63'd0, r.ok});
                    chk("resp_xfer_count", {48'd0, xfer_count}, {48'd0, r.cnt});
                    if (r.at >= 0) chk("resp_cycle", 64'(cyc), 64'(r.at));
                end
            end
            if (ttu_state == IRQC_PC_SWAP) begin
                if (swap_q.size() == 0) begin
                    chk("unexpected_pc_swap", 64'd1, 64'd0);
                end else begin
                    swap_t s;
                    s = swap_q.pop_front();
                    chk("swap_load_pc", {32'd0, ttu_load_PC}, {32'd0, s.pc});
                    chk("swap_wid", {62'd0, ttu_wid}, {62'd0, s.wid});
                    chk("swap_tid", {62'd0, ttu_tid}, {62'd0, s.tid});
                    chk("swap_tmask_zero", {60'd0, ttu_load_tmask}, 64'd0);
                end
            end else if (ttu_state == IRQC_REVERT_WARP) begin
                if (rev_q.size() == 0) begin
                    chk("unexpected_revert", 64'd1, 64'd0);
                end else begin
                    rev_t v;
                    v = rev_q.pop_front();
                    chk("revert_pc", {32'd0, ttu_load_PC}, {32'd0, v.pc});
                    chk("revert_tmask", {60'd0, ttu_load_tmask}, {60'd0, v.tmask});
                    chk("revert_wmask", {61'd0, ttu_load_wmask}, {61'd0, v.wmask});
                end
            end else if (ttu_load_PC != 32'd0) begin
                chk("idle_load_pc_zero", {32'd0, ttu_load_PC}, 64'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tick(3);
        reset = 1'b0;
        tick(1);
        chk("reset_state", {61'd0, ttu_state}, 64'd0);
        chk("reset_ready", {63'd0, irq_ready}, 64'd1);
        chk("reset_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("reset_xfer_count", {48'd0, xfer_count}, 64'd0);

        // Nominal transfer
        request(2'd1, 2'd2);
        tick(2);
        swap_q.push_back('{32'h8000_0000, 2'd1, 2'd2});
        rev_q.push_back('{32'h100, 4'hF, 3'h3});
        resp_q.push_back('{1'b1, 16'd1, -1});
        drained = 1'b1; found = 1'b1;
        cur_pc = 32'h100; cur_tmask = 4'hF; cur_wmask = 3'h3;
        tick(1);
        drained = 1'b0; found = 1'b0;
        wait_state(IRQC_WAIT_ISR, 3);
        tick(9);
        isr_done = 1'b1;
        tick(1);
        isr_done = 1'b0;
        wait_state(IRQC_IDLE, 4);
        tick(2);

        // Timeout nack, eight cycles after WAIT entry
        request(2'd0, 2'd1);
        n = cyc;
        resp_q.push_back('{1'b0, 16'd1, n + 8});
        wait_state(IRQC_IDLE, 20);
        tick(2);

        // Drain on the timeout cycle wins
        request(2'd2, 2'd0);
        tick(7);
        swap_q.push_back('{32'h8000_0000, 2'd2, 2'd0});
        rev_q.push_back('{32'h200, 4'h5, 3'h1});
        resp_q.push_back('{1'b1, 16'd2, -1});
        drained = 1'b1; found = 1'b1;
        cur_pc = 32'h200; cur_tmask = 4'h5; cur_wmask = 3'h1;
        tick(1);
        drained = 1'b0; found = 1'b0;
        chk("drain_beats_timeout", {61'd0, ttu_state}, {61'd0, IRQC_PC_SWAP});
        tick(1);

        // Busy request held through WAIT_ISR, then thread absent
        irq_valid = 1'b1; irq_wid = 2'd1; irq_tid = 2'd3;
        tick(2);
        chk("busy_ready_low", {63'd0, irq_ready}, 64'd0);
        isr_done = 1'b1;
        tick(1);
        isr_done = 1'b0;
        chk("busy_revert_ready_low", {63'd0, irq_ready}, 64'd0);
        tick(1);
        chk("busy_idle_ready", {63'd0, irq_ready}, 64'd1);
        tick(1);
        irq_valid = 1'b0;
        chk("busy_accepted", {61'd0, ttu_state}, {61'd0, IRQC_WAIT});
        chk("busy_wid", {62'd0, ttu_wid}, 64'd1);
        chk("busy_tid", {62'd0, ttu_tid}, 64'd3);
        resp_q.push_back('{1'b0, 16'd2, -1});
        drained = 1'b1; found = 1'b0;
        tick(1);
        drained = 1'b0;
        chk("absent_idle", {61'd0, ttu_state}, 64'd0);
        tick(2);

        // Out-of-range warp id
        resp_q.push_back('{1'b0, 16'd2, -1});
        request(2'd3, 2'd1);
        chk("badwid_idle", {61'd0, ttu_state}, 64'd0);
        chk("badwid_ready", {63'd0, irq_ready}, 64'd1);
        tick(3);
        chk("badwid_still_idle", {61'd0, ttu_state}, 64'd0);

        // Reset while waiting on the ISR
        request(2'd1, 2'd0);
        swap_q.push_back('{32'h8000_0000, 2'd1, 2'd0});
        drained = 1'b1; found = 1'b1; cur_pc = 32'h300;
        tick(1);
        drained = 1'b0; found = 1'b0;
        wait_state(IRQC_WAIT_ISR, 3);
        tick(2);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("rst_mid_state", {61'd0, ttu_state}, 64'd0);
        chk("rst_mid_resp", {63'd0, resp_valid}, 64'd0);
        chk("rst_mid_xfer", {48'd0, xfer_count}, 64'd0);
        chk("rst_mid_ready", {63'd0, irq_ready}, 64'd1);
        tick(5);

        chk("resp_q_empty", 64'(resp_q.size()), 64'd0);
        chk("swap_q_empty", 64'(swap_q.size()), 64'd0);
        chk("rev_q_empty", 64'(rev_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
